// File: rtl/fir_xifu_pkg.sv
// rtl/fir_xifu_pkg.sv - shared types for the FIR XIFU issue-side initiator
package fir_xifu_pkg;

   localparam int unsigned XIFU_XLEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_COMMIT = 2'd2
   } issuer_state_e;

   typedef struct packed {
      logic [XIFU_XLEN-1:0] instr;
      logic [XIFU_XLEN-1:0] rs0;
      logic [XIFU_XLEN-1:0] rs1;
   } issue_entry_t;

   typedef struct packed {
      logic accept;
      logic writeback;
      logic loadstore;
   } resp_t;

endpackage

// File: rtl/fir_xifu_issue_fifo.sv
// rtl/fir_xifu_issue_fifo.sv - show-ahead FIFO of pending issue entries
module fir_xifu_issue_fifo
   import fir_xifu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  issue_entry_t push_entry_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic         keep_head_i,
   output issue_entry_t head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   issue_entry_t   mem_q [DEPTH];
   logic [AW-1:0]  rd_ptr_q;
   logic [AW-1:0]  wr_ptr_q;
   logic [CW-1:0]  count_q;
   logic           push_ok;
   logic           pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o & ~flush_i;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   // A flush while the head is on the issue channel keeps just that entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         if (keep_head_i & ~pop_ok & ~empty_o) begin
            wr_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= CW'(1);
         end else begin
            rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
            wr_ptr_q <= rd_ptr_q + AW'(pop_ok);
            count_q  <= '0;
         end
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/fir_xifu_issuer.sv
// rtl/fir_xifu_issuer.sv - X-interface issue/commit initiator for the FIR coprocessor
module fir_xifu_issuer
   import fir_xifu_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned X_ID_WIDTH = 4,
   parameter int unsigned XLEN       = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_valid_i,
   output logic                  push_ready_o,
   input  logic [XLEN-1:0]       push_instr_i,
   input  logic [XLEN-1:0]       push_rs0_i,
   input  logic [XLEN-1:0]       push_rs1_i,
   input  logic                  flush_i,
   output logic                  issue_valid_o,
   input  logic                  issue_ready_i,
   output logic [XLEN-1:0]       issue_instr_o,
   output logic [XLEN-1:0]       issue_rs0_o,
   output logic [XLEN-1:0]       issue_rs1_o,
   output logic [1:0]            issue_rs_valid_o,
   output logic [X_ID_WIDTH-1:0] issue_id_o,
   input  logic                  issue_accept_i,
   input  logic                  issue_writeback_i,
   input  logic                  issue_loadstore_i,
   output logic                  commit_valid_o,
   output logic [X_ID_WIDTH-1:0] commit_id_o,
   output logic                  commit_kill_o,
   output logic [2:0]            last_resp_o,
   output logic [15:0]           n_accept_o,
   output logic [15:0]           n_reject_o,
   output logic                  busy_o
);

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   issuer_state_e         state_q;
   logic [X_ID_WIDTH-1:0] id_q;
   logic [X_ID_WIDTH-1:0] commit_id_q;
   logic                  commit_valid_q;
   logic                  commit_kill_q;
   resp_t                 resp_q;
   logic [15:0]           n_accept_q;
   logic [15:0]           n_reject_q;

   issue_entry_t push_entry;
   issue_entry_t head_entry;
   logic         fifo_full;
   logic         fifo_empty;
   logic         in_issue;
   logic         handshake;
   logic         push_fire;
   logic         start_next;

   assign push_entry = '{instr: push_instr_i, rs0: push_rs0_i, rs1: push_rs1_i};
   assign in_issue   = (state_q == ST_ISSUE);
   assign handshake  = in_issue & issue_ready_i;
   assign push_fire  = push_valid_i & ~fifo_full & ~flush_i;
   // A push into an idle, empty buffer starts issuing on the same edge.
   assign start_next = ~flush_i & (~fifo_empty | push_fire);

   fir_xifu_issue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (push_valid_i),
      .push_entry_i (push_entry),
      .pop_i        (handshake),
      .flush_i      (flush_i),
      .keep_head_i  (in_issue),
      .head_o       (head_entry),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         id_q           <= '0;
         commit_id_q    <= '0;
         commit_valid_q <= 1'b0;
         commit_kill_q  <= 1'b0;
         resp_q         <= '0;
         n_accept_q     <= '0;
         n_reject_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_next) begin
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_ready_i) begin
                  state_q        <= ST_COMMIT;
                  resp_q         <= '{accept:    issue_accept_i,
                                      writeback: issue_writeback_i,
                                      loadstore: issue_loadstore_i};
                  commit_valid_q <= 1'b1;
                  commit_kill_q  <= ~issue_accept_i;
                  commit_id_q    <= id_q;
               end
            end
            ST_COMMIT: begin
               commit_valid_q <= 1'b0;
               commit_kill_q  <= 1'b0;
               id_q           <= id_q + X_ID_WIDTH'(1);
               if (resp_q.accept) begin
                  if (n_accept_q != CNT_MAX) n_accept_q <= n_accept_q + 16'd1;
               end else begin
                  if (n_reject_q != CNT_MAX) n_reject_q <= n_reject_q + 16'd1;
               end
               state_q <= start_next ? ST_ISSUE : ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign push_ready_o     = ~fifo_full;
   assign issue_valid_o    = in_issue;
   assign issue_instr_o    = in_issue ? head_entry.instr : '0;
   assign issue_rs0_o      = in_issue ? head_entry.rs0 : '0;
   assign issue_rs1_o      = in_issue ? head_entry.rs1 : '0;
   assign issue_rs_valid_o = {2{in_issue}};
   assign issue_id_o       = in_issue ? id_q : '0;
   assign commit_valid_o   = commit_valid_q;
   assign commit_id_o      = commit_id_q;
   assign commit_kill_o    = commit_kill_q;
   assign last_resp_o      = resp_q;
   assign n_accept_o       = n_accept_q;
   assign n_reject_o       = n_reject_q;
   assign busy_o           = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_fir_xifu_issuer.sv
// tb/tb_fir_xifu_issuer.sv - directed self-checking bench for fir_xifu_issuer
module tb_fir_xifu_issuer;

   localparam logic [31:0] LDTAP = 32'h0000_000B;
   localparam logic [31:0] LDSAM = 32'h0000_100B;
   localparam logic [31:0] STSAM = 32'h0000_200B;
   localparam logic [31:0] BADOP = 32'h0000_700B;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        push_valid_i;
   logic        push_ready_o;
   logic [31:0] push_instr_i;
   logic [31:0] push_rs0_i;
   logic [31:0] push_rs1_i;
   logic        flush_i;
   logic        issue_valid_o;
   logic        issue_ready_i;
   logic [31:0] issue_instr_o;
   logic [31:0] issue_rs0_o;
   logic [31:0] issue_rs1_o;
   logic [1:0]  issue_rs_valid_o;
   logic [3:0]  issue_id_o;
   logic        issue_accept_i;
   logic        issue_writeback_i;
   logic        issue_loadstore_i;
   logic        commit_valid_o;
   logic [3:0]  commit_id_o;
   logic        commit_kill_o;
   logic [2:0]  last_resp_o;
   logic [15:0] n_accept_o;
   logic [15:0] n_reject_o;
   logic        busy_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] fill_tbl [4];

   always #5 clk = ~clk;

   fir_xifu_issuer #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .push_valid_i      (push_valid_i),
      .push_ready_o      (push_ready_o),
      .push_instr_i      (push_instr_i),
      .push_rs0_i        (push_rs0_i),
      .push_rs1_i        (push_rs1_i),
      .flush_i           (flush_i),
      .issue_valid_o     (issue_valid_o),
      .issue_ready_i     (issue_ready_i),
      .issue_instr_o     (issue_instr_o),
      .issue_rs0_o       (issue_rs0_o),
      .issue_rs1_o       (issue_rs1_o),
      .issue_rs_valid_o  (issue_rs_valid_o),
      .issue_id_o        (issue_id_o),
      .issue_accept_i    (issue_accept_i),
      .issue_writeback_i (issue_writeback_i),
      .issue_loadstore_i (issue_loadstore_i),
      .commit_valid_o    (commit_valid_o),
      .commit_id_o       (commit_id_o),
      .commit_kill_o     (commit_kill_o),
      .last_resp_o       (last_resp_o),
      .n_accept_o        (n_accept_o),
      .n_reject_o        (n_reject_o),
      .busy_o            (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] rs0, input logic [31:0] rs1);
      push_valid_i = 1'b1;
      push_instr_i = instr;
      push_rs0_i   = rs0;
      push_rs1_i   = rs1;
      tick();
      push_valid_i = 1'b0;
   endtask

   task automatic set_resp(input logic acc, input logic wb, input logic ls);
      issue_accept_i    = acc;
      issue_writeback_i = wb;
      issue_loadstore_i = ls;
   endtask

   initial begin
      rst_i = 1'b0; push_valid_i = 1'b0; push_instr_i = '0; push_rs0_i = '0; push_rs1_i = '0;
      flush_i = 1'b0; issue_ready_i = 1'b0;
      set_resp(1'b0, 1'b0, 1'b0);
      fill_tbl[0] = LDTAP; fill_tbl[1] = LDSAM; fill_tbl[2] = STSAM; fill_tbl[3] = LDTAP | 32'h0000_0F80;

      do_reset();
      check("rst_issue_valid", issue_valid_o, 0);
      check("rst_commit_valid", commit_valid_o, 0);
      check("rst_kill", commit_kill_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_push_ready", push_ready_o, 1);
      check("rst_n_accept", n_accept_o, 0);
      check("rst_n_reject", n_reject_o, 0);
      check("rst_last_resp", last_resp_o, 0);
      check("rst_issue_instr", issue_instr_o, 0);
      check("rst_issue_id", issue_id_o, 0);

      // single accepted LDTAP
      issue_ready_i = 1'b1;
      set_resp(1'b1, 1'b1, 1'b1);
      push(LDTAP, 32'h1000_0000, 32'h0);
      check("single_valid", issue_valid_o, 1);
      check("single_instr", issue_instr_o, LDTAP);
      check("single_rs0", issue_rs0_o, 32'h1000_0000);
      check("single_rs_valid", issue_rs_valid_o, 2'b11);
      check("single_id", issue_id_o, 0);
      tick();
      check("single_commit", commit_valid_o, 1);
      check("single_commit_id", commit_id_o, 0);
      check("single_kill", commit_kill_o, 0);
      check("single_issue_drop", issue_valid_o, 0);
      check("single_last_resp", last_resp_o, 3'b111);
      tick();
      check("single_commit_end", commit_valid_o, 0);
      check("single_n_accept", n_accept_o, 1);
      check("single_busy", busy_o, 0);

      // backpressure for five cycles
      issue_ready_i = 1'b0;
      push(LDSAM, 32'h2000_0040, 32'hDEAD_BEEF);
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", issue_valid_o, 1);
         check("bp_instr", issue_instr_o, LDSAM);
         check("bp_rs0", issue_rs0_o, 32'h2000_0040);
         check("bp_rs1", issue_rs1_o, 32'hDEAD_BEEF);
         check("bp_id", issue_id_o, 1);
         check("bp_no_commit", commit_valid_o, 0);
         if (k < 4) tick();
      end
      issue_ready_i = 1'b1;
      tick();
      check("bp_commit", commit_valid_o, 1);
      check("bp_commit_id", commit_id_o, 1);
      tick();
      check("bp_one_commit", commit_valid_o, 0);
      check("bp_idle", issue_valid_o, 0);
      check("bp_n_accept", n_accept_o, 2);

      // rejected instruction
      set_resp(1'b0, 1'b0, 1'b0);
      push(BADOP, 32'h3000_0000, 32'h0);
      check("rej_id", issue_id_o, 2);
      tick();
      check("rej_commit", commit_valid_o, 1);
      check("rej_kill", commit_kill_o, 1);
      check("rej_commit_id", commit_id_o, 2);
      check("rej_last_resp", last_resp_o, 3'b000);
      tick();
      check("rej_n_reject", n_reject_o, 1);
      check("rej_n_accept", n_accept_o, 2);
      check("rej_kill_end", commit_kill_o, 0);

      // fill the buffer under backpressure
      do_reset();
      issue_ready_i = 1'b0;
      set_resp(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("fill_ready_before", push_ready_o, 1);
         push(fill_tbl[i], 32'h4000_0000 + i, 32'h0);
      end
      check("fill_full", push_ready_o, 0);
      push(BADOP, 32'h5555_5555, 32'h0);
      issue_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("fill_valid", issue_valid_o, 1);
         check("fill_instr", issue_instr_o, fill_tbl[i]);
         check("fill_rs0", issue_rs0_o, 32'h4000_0000 + i);
         check("fill_id", issue_id_o, i);
         tick();
         check("fill_commit", commit_valid_o, 1);
         check("fill_commit_id", commit_id_o, i);
         check("fill_gap", issue_valid_o, 0);
         tick();
      end
      check("fill_drained", issue_valid_o, 0);
      check("fill_busy", busy_o, 0);
      check("fill_last_resp", last_resp_o, 3'b101);

      // id wrap over 17 transactions
      do_reset();
      issue_ready_i = 1'b1;
      set_resp(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) begin
         push(STSAM, 32'h6000_0000, i);
         check("wrap_issue_id", issue_id_o, i % 16);
         tick();
         check("wrap_commit_id", commit_id_o, i % 16);
         tick();
      end
      check("wrap_n_accept", n_accept_o, 17);
      check("wrap_n_reject", n_reject_o, 0);

      // flush while the head is being offered
      do_reset();
      issue_ready_i = 1'b0;
      set_resp(1'b1, 1'b1, 1'b1);
      push(LDTAP, 32'h7000_0000, 0);
      push(LDSAM, 32'h7000_0004, 0);
      push(STSAM, 32'h7000_0008, 0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_head_kept", issue_valid_o, 1);
      check("flush_head_instr", issue_instr_o, LDTAP);
      check("flush_busy", busy_o, 1);
      check("flush_ready", push_ready_o, 1);
      issue_ready_i = 1'b1;
      tick();
      check("flush_commit", commit_valid_o, 1);
      check("flush_commit_id", commit_id_o, 0);
      tick();
      check("flush_busy_done", busy_o, 0);
      for (int k = 0; k < 3; k++) begin
         check("flush_no_issue", issue_valid_o, 0);
         tick();
      end
      check("flush_n_accept", n_accept_o, 1);

      // reset in the middle of an issue
      issue_ready_i = 1'b0;
      push(LDSAM, 32'h8000_0000, 32'h1);
      check("midrst_valid", issue_valid_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("midrst_issue_valid", issue_valid_o, 0);
      check("midrst_commit", commit_valid_o, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_push_ready", push_ready_o, 1);
      check("midrst_instr", issue_instr_o, 0);
      check("midrst_n_accept", n_accept_o, 0);
      tick();
      check("midrst_no_commit", commit_valid_o, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
